// File: rtl/tristate_bus_reader_pkg.sv
// Shared types and constants for the tri-state bus reader.
package tristate_bus_reader_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSelect  = 2'd1,
    StRespond = 2'd2
  } state_e;

  localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/tristate_cs_decoder.sv
// Combinational map from (enable, index) to an active-low one-hot chip-select vector.
module tristate_cs_decoder #(
  parameter int unsigned NrOfSlaves = 4,
  parameter int unsigned AddrBits   = 2
) (
  input  logic                  enable,
  input  logic [AddrBits-1:0]   index,
  output logic [NrOfSlaves-1:0] cs
);

  // Out-of-range indices match no bit, so every slave stays released.
  always_comb begin
    cs = '1;
    for (int i = 0; i < NrOfSlaves; i++) begin
      if (enable && (index == AddrBits'(i))) begin
        cs[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_reader.sv
// Reads one chip-selected slave off a shared tri-state bus and returns the word on a
// valid/ready response channel.
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfBits         = 32,
  parameter int unsigned NrOfSlaves       = 4,
  parameter int unsigned AddrBits         = 2,
  parameter int unsigned TurnaroundCycles = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [AddrBits-1:0]   ReqAddr,
  input  logic [NrOfBits-1:0]   BusData,
  output logic [NrOfSlaves-1:0] Cs,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [NrOfBits-1:0]   RspData,
  output logic                  RspErr
);

  localparam logic [AddrBits:0]   NrSlavesW = (AddrBits + 1)'(NrOfSlaves);
  localparam logic [CntWidth-1:0] TaInit    = CntWidth'(TurnaroundCycles);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [NrOfBits-1:0]   data_q, data_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (ReqValid) begin
          if ({1'b0, ReqAddr} < NrSlavesW) begin
            state_d = StSelect;
            addr_d  = ReqAddr;
            cnt_d   = TaInit;
          end else begin
            state_d = StRespond;
            err_d   = 1'b1;
            data_d  = '0;
          end
        end
      end
      StSelect: begin
        if (Tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            data_d  = BusData;
            err_d   = 1'b0;
            state_d = StRespond;
          end
        end
      end
      StRespond: begin
        if (RspReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Cs decodes straight from the async-reset state register, so Reset releases the bus
  // without waiting for an edge.
  tristate_cs_decoder #(
    .NrOfSlaves (NrOfSlaves),
    .AddrBits   (AddrBits)
  ) u_cs_decoder (
    .enable (state_q == StSelect),
    .index  (addr_q),
    .cs     (Cs)
  );

  assign ReqReady = (state_q == StIdle);
  assign RspValid = (state_q == StRespond);
  assign RspData  = data_q;
  assign RspErr   = err_q;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed bench for tristate_bus_reader: a 4-slave instance plus a 3-slave one for the
// out-of-range path.
module tb_tristate_bus_reader;

  logic        Clock;
  logic        Reset;
  logic        Tick;
  logic        ReqValid;
  logic        ReqReady;
  logic [1:0]  ReqAddr;
  logic [31:0] BusData;
  logic [3:0]  Cs;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspErr;

  logic        req_valid3;
  logic        req_ready3;
  logic [1:0]  req_addr3;
  logic [2:0]  cs3;
  logic        rsp_valid3;
  logic [31:0] rsp_data3;
  logic        rsp_err3;

  logic [31:0] slave_val [4];

  int n_cmp;
  int n_err;
  int multi_low;
  int respond_cs_low;
  int cs3_low;

  tristate_bus_reader #(
    .NrOfBits(32), .NrOfSlaves(4), .AddrBits(2), .TurnaroundCycles(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .BusData(BusData), .Cs(Cs), .RspValid(RspValid),
    .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr)
  );

  tristate_bus_reader #(
    .NrOfBits(32), .NrOfSlaves(3), .AddrBits(2), .TurnaroundCycles(1)
  ) dut3 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .ReqValid(req_valid3), .ReqReady(req_ready3),
    .ReqAddr(req_addr3), .BusData(BusData), .Cs(cs3), .RspValid(rsp_valid3),
    .RspReady(RspReady), .RspData(rsp_data3), .RspErr(rsp_err3)
  );

  // Slave model: each slave drives only while its select is low.
  always_comb begin
    BusData = 'z;
    for (int k = 0; k < 4; k++) begin
      if (!Cs[k]) BusData = slave_val[k];
    end
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(negedge Clock) begin
    if ($countones(~Cs) > 1) multi_low <= multi_low + 1;
    if (RspValid && (Cs != 4'b1111)) respond_cs_low <= respond_cs_low + 1;
    if (cs3 != 3'b111) cs3_low <= cs3_low + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] held;

  initial begin
    n_cmp = 0; n_err = 0; multi_low = 0; respond_cs_low = 0; cs3_low = 0;
    Reset = 1'b1; Tick = 1'b1; ReqValid = 1'b0; ReqAddr = 2'd0; RspReady = 1'b0;
    req_valid3 = 1'b0; req_addr3 = 2'd0;
    slave_val[0] = 32'h1111_1111; slave_val[1] = 32'h2222_2222;
    slave_val[2] = 32'hDEAD_BEEF; slave_val[3] = 32'hA5A5_5A5A;
    step(); step();
    check("rst_cs", {28'd0, Cs}, 32'hF);
    check("rst_req_ready", {31'd0, ReqReady}, 32'd1);
    check("rst_rsp_valid", {31'd0, RspValid}, 32'd0);
    check("rst_rsp_data", RspData, 32'd0);
    check("rst_rsp_err", {31'd0, RspErr}, 32'd0);
    Reset = 1'b0;
    step();

    // Basic read of slave 2, TA=1, Tick held high.
    ReqValid = 1'b1; ReqAddr = 2'd2;
    step();
    ReqValid = 1'b0;
    check("basic_cs_e0", {28'd0, Cs}, 32'hB);
    check("basic_ready_e0", {31'd0, ReqReady}, 32'd0);
    check("basic_valid_e0", {31'd0, RspValid}, 32'd0);
    step();
    check("basic_cs_e1", {28'd0, Cs}, 32'hB);
    check("basic_valid_e1", {31'd0, RspValid}, 32'd0);
    step();
    check("basic_valid_e2", {31'd0, RspValid}, 32'd1);
    check("basic_data", RspData, 32'hDEAD_BEEF);
    check("basic_err", {31'd0, RspErr}, 32'd0);
    check("basic_cs_e2", {28'd0, Cs}, 32'hF);
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
    check("basic_done_valid", {31'd0, RspValid}, 32'd0);
    check("basic_done_ready", {31'd0, ReqReady}, 32'd1);

    // Backpressure on a read of slave 3.
    ReqValid = 1'b1; ReqAddr = 2'd3;
    step();
    step();
    step();
    held = 32'hA5A5_5A5A;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, RspValid}, 32'd1);
      check("bp_data", RspData, held);
      check("bp_cs", {28'd0, Cs}, 32'hF);
      check("bp_ready", {31'd0, ReqReady}, 32'd0);
      step();
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
    check("bp_done_valid", {31'd0, RspValid}, 32'd0);

    // Tick every 3rd cycle; bus value changes between the two ticked edges.
    Tick = 1'b0;
    slave_val[0] = 32'h0BAD_F00D;
    ReqValid = 1'b1; ReqAddr = 2'd0;
    step();
    ReqValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Tick = (i % 3 == 2);
      if (i == 3) slave_val[0] = 32'h600D_CAFE;
      step();
      if (i < 5) begin
        check("tick_cs", {28'd0, Cs}, 32'hE);
        check("tick_valid", {31'd0, RspValid}, 32'd0);
      end
    end
    check("tick_valid_end", {31'd0, RspValid}, 32'd1);
    check("tick_data", RspData, 32'h600D_CAFE);
    Tick = 1'b1;
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;

    // Back-to-back reads of slaves 0 and 1.
    slave_val[0] = 32'h1111_1111;
    ReqValid = 1'b1; ReqAddr = 2'd0;
    step();
    ReqAddr = 2'd1;
    step();
    step();
    check("b2b_data0", RspData, 32'h1111_1111);
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
    check("b2b_gap_cs", {28'd0, Cs}, 32'hF);
    step();
    ReqValid = 1'b0;
    check("b2b_cs1", {28'd0, Cs}, 32'hD);
    step();
    step();
    check("b2b_valid1", {31'd0, RspValid}, 32'd1);
    check("b2b_data1", RspData, 32'h2222_2222);
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;

    // Out-of-range address on the 3-slave instance.
    req_valid3 = 1'b1; req_addr3 = 2'd3;
    step();
    req_valid3 = 1'b0;
    check("err_valid", {31'd0, rsp_valid3}, 32'd1);
    check("err_flag", {31'd0, rsp_err3}, 32'd1);
    check("err_data", rsp_data3, 32'd0);
    check("err_cs", {29'd0, cs3}, 32'h7);
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
    check("err_done", {31'd0, rsp_valid3}, 32'd0);

    // Asynchronous reset mid-SELECT releases Cs before the next edge.
    ReqValid = 1'b1; ReqAddr = 2'd1;
    step();
    ReqValid = 1'b0;
    check("arst_pre_cs", {28'd0, Cs}, 32'hD);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_cs", {28'd0, Cs}, 32'hF);
    check("arst_valid", {31'd0, RspValid}, 32'd0);
    check("arst_ready", {31'd0, ReqReady}, 32'd1);
    check("arst_data", RspData, 32'd0);
    step();
    Reset = 1'b0;
    step();

    check("inv_multi_low", multi_low, 32'd0);
    check("inv_respond_cs", respond_cs_low, 32'd0);
    check("inv_cs3_never_low", cs3_low, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
